// File: rtl/mandelbrot_band.sv
// rtl/mandelbrot_band.sv - interleaved-band fractal renderer with N_ENG pixel engines and a framebuffer
//
// mandelbrot_pxl: one escape-time engine, one iteration per clock.
//   start/z_re/z_im/c_re/c_im/iters in; busy, dout_valid (1-cycle pulse), dout (count) out.
// mandelbrot_band: renders rows y with y mod N_BANDS == BAND_INDEX.
//   start/julia/x_i/y_i/x_step/y_step/iters/c_re/c_im : render request, latched on start.
//   rd_en/rd_x/rd_y -> rd_valid/rd_hit/rd_data       : registered framebuffer read port.
//   busy/done                                          : render status.

module mandelbrot_pxl #(
    parameter int W = 32,
    parameter int P = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] z_re,
    input  logic signed [W-1:0] z_im,
    input  logic signed [W-1:0] c_re,
    input  logic signed [W-1:0] c_im,
    input  logic [31:0]         iters,
    output logic                busy,
    output logic                dout_valid,
    output logic [31:0]         dout
);
    // Full-precision squares so the escape test cannot overflow.
    localparam int PW = 2 * W + 1;
    localparam logic signed [PW-1:0] LIMIT = {{(PW-3){1'b0}}, 3'b100} << (2 * P);

    logic signed [W-1:0]  zr, zi, cr, ci;
    logic [31:0]          max_q, cnt;
    logic signed [PW-1:0] ezr, ezi, sr, si, pr;
    logic                 escape;

    assign ezr    = {{(W+1){zr[W-1]}}, zr};
    assign ezi    = {{(W+1){zi[W-1]}}, zi};
    assign sr     = ezr * ezr;
    assign si     = ezi * ezi;
    assign pr     = ezr * ezi;
    assign escape = (sr + si) > LIMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            zr         <= '0;
            zi         <= '0;
            cr         <= '0;
            ci         <= '0;
            max_q      <= '0;
            cnt        <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (start && !busy) begin
                zr    <= z_re;
                zi    <= z_im;
                cr    <= c_re;
                ci    <= c_im;
                max_q <= iters;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                if (cnt == max_q || escape) begin
                    busy       <= 1'b0;
                    dout_valid <= 1'b1;
                    dout       <= cnt;
                end else begin
                    // z <- z^2 + c; the imaginary shift by P-1 folds in the factor 2.
                    zr  <= W'((sr - si) >>> P) + cr;
                    zi  <= W'(pr >>> (P - 1)) + ci;
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end
endmodule

module mandelbrot_band #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int N_BANDS    = 4,
    parameter int BAND_INDEX = 0,
    parameter int N_ENG      = 2,
    parameter int DIN_WIDTH  = 32,
    parameter int DIN_POINT  = 12,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        julia,
    input  logic signed [DIN_WIDTH-1:0] x_i,
    input  logic signed [DIN_WIDTH-1:0] y_i,
    input  logic signed [DIN_WIDTH-1:0] x_step,
    input  logic signed [DIN_WIDTH-1:0] y_step,
    input  logic [31:0]                 iters,
    input  logic signed [DIN_WIDTH-1:0] c_re,
    input  logic signed [DIN_WIDTH-1:0] c_im,
    input  logic                        rd_en,
    input  logic [$clog2(H_RES)-1:0]    rd_x,
    input  logic [$clog2(V_RES)-1:0]    rd_y,
    output logic [DOUT_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic                        rd_hit,
    output logic                        busy,
    output logic                        done
);
    localparam int DEPTH  = H_RES * V_RES / N_BANDS;
    localparam int AW     = $clog2(DEPTH);
    localparam int XW     = $clog2(H_RES);
    localparam int NB_LOG = $clog2(N_BANDS);
    localparam int EW     = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [32:0] SAT_MAX = (33'd1 << DOUT_WIDTH) - 33'd1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic                        julia_q;
    logic signed [DIN_WIDTH-1:0] x_i_q, x_step_q, ystep_band_q, cre_q, cim_q;
    logic signed [DIN_WIDTH-1:0] x_acc, y_acc, c_sel_re, c_sel_im;
    logic [31:0]                 iters_q;
    logic [XW-1:0]               px_q;
    logic [AW-1:0]               disp_addr, wr_cnt, wr_addr, rd_addr;
    logic [DOUT_WIDTH-1:0]       wr_data;
    logic [N_ENG-1:0]            inflight, pend, free, eng_start, eng_busy, eng_valid;
    logic [AW-1:0]               addr_q  [N_ENG];
    logic [DOUT_WIDTH-1:0]       res_q   [N_ENG];
    logic [31:0]                 eng_dout [N_ENG];
    logic [EW-1:0]               disp_sel, wr_sel;
    logic                        start_ok, disp_en, wr_en, rd_own;
    logic [DOUT_WIDTH-1:0]       mem [DEPTH];

    function automatic logic [DOUT_WIDTH-1:0] sat(input logic [31:0] v);
        if ({1'b0, v} > SAT_MAX) return '1;
        return DOUT_WIDTH'(v);
    endfunction

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign free     = ~eng_busy & ~inflight & ~pend;
    assign disp_en  = (state_q == S_RUN) && (|free);
    assign wr_en    = |pend;
    assign wr_addr  = addr_q[wr_sel];
    assign wr_data  = res_q[wr_sel];
    assign c_sel_re = julia_q ? cre_q : x_acc;
    assign c_sel_im = julia_q ? cim_q : y_acc;
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

    // Lowest index wins for both dispatch and write-back.
    always_comb begin
        disp_sel = '0;
        wr_sel   = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (free[i]) disp_sel = EW'(i);
            if (pend[i]) wr_sel   = EW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_RUN;
            S_RUN:   if (disp_en && disp_addr == AW'(DEPTH - 1)) state_d = S_DRAIN;
            S_DRAIN: if (wr_en && wr_cnt == AW'(DEPTH - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            julia_q      <= 1'b0;
            x_i_q        <= '0;
            x_step_q     <= '0;
            ystep_band_q <= '0;
            cre_q        <= '0;
            cim_q        <= '0;
            iters_q      <= '0;
            x_acc        <= '0;
            y_acc        <= '0;
            px_q         <= '0;
            disp_addr    <= '0;
            wr_cnt       <= '0;
            inflight     <= '0;
            pend         <= '0;
            for (int i = 0; i < N_ENG; i++) begin
                addr_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            if (start_ok) begin
                julia_q      <= julia;
                x_i_q        <= x_i;
                x_step_q     <= x_step;
                ystep_band_q <= y_step <<< NB_LOG;
                cre_q        <= c_re;
                cim_q        <= c_im;
                iters_q      <= iters;
                x_acc        <= x_i;
                y_acc        <= y_i + y_step * $signed(DIN_WIDTH'(BAND_INDEX));
                px_q         <= '0;
                disp_addr    <= '0;
                wr_cnt       <= '0;
            end
            if (disp_en) begin
                disp_addr <= disp_addr + AW'(1);
                if (px_q == XW'(H_RES - 1)) begin
                    px_q  <= '0;
                    x_acc <= x_i_q;
                    y_acc <= y_acc + ystep_band_q;
                end else begin
                    px_q  <= px_q + XW'(1);
                    x_acc <= x_acc + x_step_q;
                end
            end
            if (wr_en) wr_cnt <= wr_cnt + AW'(1);
            for (int i = 0; i < N_ENG; i++) begin
                if (eng_start[i]) begin
                    inflight[i] <= 1'b1;
                    addr_q[i]   <= disp_addr;
                end else if (eng_valid[i] && inflight[i]) begin
                    // Results without an in-flight flag are stale and dropped.
                    inflight[i] <= 1'b0;
                    pend[i]     <= 1'b1;
                    res_q[i]    <= sat(eng_dout[i]);
                end
                if (wr_en && wr_sel == EW'(i)) pend[i] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_ENG; g++) begin : g_eng
        assign eng_start[g] = disp_en && (disp_sel == EW'(g));
        mandelbrot_pxl #(.W(DIN_WIDTH), .P(DIN_POINT)) u_eng (
            .clk        (clk),
            .rst        (rst),
            .start      (eng_start[g]),
            .z_re       (x_acc),
            .z_im       (y_acc),
            .c_re       (c_sel_re),
            .c_im       (c_sel_im),
            .iters      (iters_q),
            .busy       (eng_busy[g]),
            .dout_valid (eng_valid[g]),
            .dout       (eng_dout[g])
        );
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_own  = ((32'(rd_y) & (N_BANDS - 1)) == BAND_INDEX);
    assign rd_addr = AW'(32'(rd_x) + (32'(rd_y) >> NB_LOG) * H_RES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en && state_q == S_DONE && rd_own) begin
                rd_hit  <= 1'b1;
                rd_data <= mem[rd_addr];
            end else begin
                rd_hit  <= 1'b0;
                rd_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mandelbrot_band.sv
// tb/tb_mandelbrot_band.sv - directed, table-driven bench for mandelbrot_band

module tb_mandelbrot_band;
    logic               clk = 1'b0;
    logic               rst, start, julia, rd_en;
    logic signed [31:0] x_i, y_i, x_step, y_step, c_re, c_im;
    logic [31:0]        iters;
    logic [2:0]         rd_x, rd_y;
    logic [15:0]        rd_data;
    logic [3:0]         rd_data_s;
    logic               rd_valid, rd_hit, busy, done;
    logic               rd_valid_s, rd_hit_s, busy_s, done_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mandelbrot_band #(.H_RES(8), .V_RES(8), .N_BANDS(2), .BAND_INDEX(1), .N_ENG(2),
                      .DIN_WIDTH(32), .DIN_POINT(12), .DOUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .julia(julia),
        .x_i(x_i), .y_i(y_i), .x_step(x_step), .y_step(y_step), .iters(iters),
        .c_re(c_re), .c_im(c_im), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit), .busy(busy), .done(done));

    mandelbrot_band #(.H_RES(8), .V_RES(8), .N_BANDS(2), .BAND_INDEX(1), .N_ENG(2),
                      .DIN_WIDTH(32), .DIN_POINT(12), .DOUT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .julia(julia),
        .x_i(x_i), .y_i(y_i), .x_step(x_step), .y_step(y_step), .iters(iters),
        .c_re(c_re), .c_im(c_im), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .rd_hit(rd_hit_s), .busy(busy_s), .done(done_s));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Escape-time reference: z0 = pixel, c = pixel or (0,0), Q12 arithmetic.
    function automatic int golden(input logic j, input int it, input int px, input int gy);
        logic signed [31:0] zr, zi, cr, ci;
        logic signed [64:0] ezr, ezi, sr, si, pr, t;
        int cnt;
        zr = -32'sd8192 + px * 2048;
        zi = -32'sd8192 + gy * 2048;
        cr = j ? 32'sd0 : zr;
        ci = j ? 32'sd0 : zi;
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            ezr = zr;
            ezi = zi;
            sr = ezr * ezr;
            si = ezi * ezi;
            pr = ezr * ezi;
            if (cnt == it || (sr + si) > 65'sd67108864) return cnt;
            t  = (sr - si) >>> 12;
            zr = t[31:0] + cr;
            t  = pr >>> 11;
            zi = t[31:0] + ci;
            cnt++;
        end
        return cnt;
    endfunction

    // Back-to-back read of every framebuffer location, checked one cycle later.
    task automatic scan(input logic j, input int it);
        int p, ex, ey, eg;
        logic eh;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k > 0) begin
                p  = k - 1;
                ex = p % 8;
                ey = p / 8;
                eh = (ey % 2) == 1;
                eg = eh ? golden(j, it, ex, ey) : 0;
                chk($sformatf("scan_valid(%0d,%0d)", ex, ey), rd_valid, 1);
                chk($sformatf("scan_hit(%0d,%0d)", ex, ey), rd_hit, eh);
                chk($sformatf("scan_data(%0d,%0d)", ex, ey), rd_data, eg);
                chk($sformatf("scan_sat(%0d,%0d)", ex, ey), rd_data_s, (eg > 15) ? 15 : eg);
            end
            if (k < 64) begin
                rd_en = 1'b1;
                rd_x  = 3'(k % 8);
                rd_y  = 3'(k / 8);
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    task automatic do_render(input logic j, input int it, input int poke, input int abort_at);
        int wr, last, seen[32];
        bit ok;
        @(negedge clk);
        julia = j; iters = it; x_i = -32'sd8192; y_i = -32'sd8192;
        x_step = 32'sd2048; y_step = 32'sd2048; c_re = 0; c_im = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        wr = 0; last = -1; ok = 1'b0;
        foreach (seen[a]) seen[a] = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (abort_at > 0 && wr == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_idle_busy", busy, 0);
                chk("abort_idle_done", done, 0);
                return;
            end
            if (dut.wr_en) begin
                wr++;
                seen[dut.wr_addr]++;
                last = cyc;
            end
            if (cyc == poke) begin
                start = 1'b1; julia = ~j; x_i = 0;
            end else if (cyc == poke + 1) begin
                start = 1'b0; julia = j; x_i = -32'sd8192;
            end
            if (done) begin
                ok = 1'b1;
                chk("done_after_last_write", cyc - last, 1);
                break;
            end
            @(negedge clk);
        end
        chk("render_timeout", ok, 1);
        chk("write_count", wr, 32);
        foreach (seen[a]) if (seen[a] != 1) chk($sformatf("addr_once[%0d]", a), seen[a], 1);
        chk("busy_at_done", busy, 0);
        scan(j, it);
    endtask

    typedef struct {
        logic j;
        int   it;
        int   rx;
        int   ry;
        logic hit;
        int   data;
        int   sdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cur_j;
        int   cur_it;
        vecs[0]  = '{1'b0, 16,  4, 5, 1'b1, 16,  15};
        vecs[1]  = '{1'b0, 16,  0, 1, 1'b1, 0,   0};
        vecs[2]  = '{1'b0, 16,  2, 3, 1'b1, 4,   4};
        vecs[3]  = '{1'b0, 16,  3, 5, 1'b1, 16,  15};
        vecs[4]  = '{1'b0, 16,  4, 4, 1'b0, 0,   0};
        vecs[5]  = '{1'b0, 100, 4, 5, 1'b1, 100, 15};
        vecs[6]  = '{1'b0, 100, 2, 3, 1'b1, 4,   4};
        vecs[7]  = '{1'b0, 1,   4, 5, 1'b1, 1,   1};
        vecs[8]  = '{1'b0, 1,   2, 3, 1'b1, 1,   1};
        vecs[9]  = '{1'b0, 1,   0, 1, 1'b1, 0,   0};
        vecs[10] = '{1'b1, 16,  4, 5, 1'b1, 16,  15};
        vecs[11] = '{1'b1, 16,  2, 3, 1'b1, 3,   3};
        vecs[12] = '{1'b1, 16,  0, 1, 1'b1, 0,   0};
        vecs[13] = '{1'b1, 16,  7, 6, 1'b0, 0,   0};

        rst = 1'b0; start = 1'b0; julia = 1'b0; rd_en = 1'b0; rd_x = 0; rd_y = 0;
        x_i = 0; y_i = 0; x_step = 0; y_step = 0; c_re = 0; c_im = 0; iters = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = k[0];
            rd_en = ~k[0];
            rd_y  = 3'd5;
        end
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_hit", rd_hit, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_sat_busy", busy_s, 0);
        start = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        cur_j = 1'b0; cur_it = -1;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].j != cur_j || vecs[i].it != cur_it) begin
                cur_j = vecs[i].j;
                cur_it = vecs[i].it;
                do_render(cur_j, cur_it, (i == 0) ? 5 : -10, 0);
            end
            @(negedge clk);
            rd_en = 1'b1; rd_x = 3'(vecs[i].rx); rd_y = 3'(vecs[i].ry);
            @(negedge clk);
            rd_en = 1'b0;
            chk($sformatf("vec%0d_valid", i), rd_valid, 1);
            chk($sformatf("vec%0d_hit", i), rd_hit, vecs[i].hit);
            chk($sformatf("vec%0d_data", i), rd_data, vecs[i].data);
            chk($sformatf("vec%0d_sat", i), rd_data_s, vecs[i].sdata);
            chk($sformatf("vec%0d_sat_hit", i), rd_hit_s, vecs[i].hit);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_drop", i), rd_valid, 0);
        end

        do_render(1'b0, 16, -10, 10);
        do_render(1'b0, 16, -10, 0);
        @(negedge clk);
        rd_en = 1'b1; rd_x = 3'd4; rd_y = 3'd5;
        @(negedge clk);
        rd_en = 1'b0;
        chk("post_reset_hit", rd_hit, 1);
        chk("post_reset_data", rd_data, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
